// File: rtl/ram_wr_nibble_packer.sv
// ram_wr_nibble_packer
// Packs the 4-bit nibble stream leaving the fabric into NIBBLES_PER_WORD-wide
// RAM write words, with an auto-incrementing write address and a per-nibble
// write mask.
//
// Handshakes (both sides use strict valid/ready semantics):
//   - A nibble transfers on a rising edge where nib_valid && nib_ready.
//   - A write transfers on a rising edge where ram_we && ram_ready.
//   - Once ram_we is raised, the request (ram_addr, ram_wdata, ram_nmask,
//     ram_last) stays stable until ram_ready is seen.
//   - nib_ready = !ram_we || ram_ready, so a completing nibble can never
//     overwrite a held request, and throughput is one nibble per cycle.
module ram_wr_nibble_packer #(
    parameter int NIBBLES_PER_WORD = 8,
    parameter int ADDR_WIDTH       = 8,
    parameter int NoConfigBits     = 2
) (
    input  logic                            UserCLK,
    input  logic                            UserRSTn,
    input  logic [3:0]                      nib_data,
    input  logic                            nib_valid,
    input  logic                            nib_last,
    output logic                            nib_ready,
    output logic                            ram_we,
    input  logic                            ram_ready,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [4*NIBBLES_PER_WORD-1:0]   ram_wdata,
    output logic [NIBBLES_PER_WORD-1:0]     ram_nmask,
    output logic                            ram_last,
    output logic                            pkt_done,
    input  logic [NoConfigBits-1:0]         ConfigBits
);

    localparam int N  = NIBBLES_PER_WORD;
    localparam int W  = 4 * N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0]         cnt;
    logic [W-1:0]          acc;
    logic [N-1:0]          accMask;
    logic [ADDR_WIDTH-1:0] addrCnt;
    logic [ADDR_WIDTH-1:0] addrNext;

    logic                  nibAccept;
    logic                  wrAccept;
    logic                  wordDone;
    logic [CW-1:0]         slot;
    logic [W-1:0]          mergedWord;
    logic [N-1:0]          mergedMask;

    assign nib_ready = !ram_we || ram_ready;
    assign nibAccept = nib_valid && nib_ready;
    assign wrAccept  = ram_we && ram_ready;
    assign wordDone  = nibAccept && (nib_last || (cnt == CW'(N - 1)));

    // ConfigBits[0] selects whether the first nibble lands in the bottom or top slot
    assign slot = ConfigBits[0] ? (CW'(N - 1) - cnt) : cnt;

    // Merge the incoming nibble into its slot of the partial word
    always_comb begin
        mergedWord = acc;
        mergedMask = accMask;
        for (int i = 0; i < N; i++) begin
            if (slot == CW'(i)) begin
                mergedWord[4*i +: 4] = nib_data;
                mergedMask[i]        = 1'b1;
            end
        end
    end

    // Address after this cycle's write (if any); a word completing in the same
    // cycle as a write must pick up the advanced address, not the stale one
    always_comb begin
        addrNext = addrCnt;
        if (wrAccept) begin
            if (ram_last && ConfigBits[1]) begin
                addrNext = '0;
            end else begin
                addrNext = addrCnt + 1'b1;
            end
        end
    end

    // Partial-word accumulator, cleared whenever a word is handed to the output
    always_ff @(posedge UserCLK or negedge UserRSTn) begin
        if (!UserRSTn) begin
            cnt     <= '0;
            acc     <= '0;
            accMask <= '0;
        end else if (wordDone) begin
            cnt     <= '0;
            acc     <= '0;
            accMask <= '0;
        end else if (nibAccept) begin
            cnt     <= cnt + 1'b1;
            acc     <= mergedWord;
            accMask <= mergedMask;
        end
    end

    // Write-address counter, advancing on each accepted write
    always_ff @(posedge UserCLK or negedge UserRSTn) begin
        if (!UserRSTn) begin
            addrCnt <= '0;
        end else begin
            addrCnt <= addrNext;
        end
    end

    // Output request register and packet-done pulse
    always_ff @(posedge UserCLK or negedge UserRSTn) begin
        if (!UserRSTn) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_nmask <= '0;
            ram_last  <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            pkt_done <= wrAccept && ram_last;
            if (wordDone) begin
                ram_we    <= 1'b1;
                ram_addr  <= addrNext;
                ram_wdata <= mergedWord;
                ram_nmask <= mergedMask;
                ram_last  <= nib_last;
            end else if (wrAccept) begin
                ram_we <= 1'b0;
            end
        end
    end

endmodule
